input_conditioner: RTL

Parametrised, multi-channel successor to the per-button input registers for the controller (Dpad, A, B, Pause). Each channel is synchronised to `CLK`, debounced with a programmable stable-time counter and optionally polarity-inverted. The block then produces a clean level plus single-cycle press, release and auto-repeat pulses. It sits between the raw controller pins and the game logic (Mario movement, pause and menu handling).

---
 rtl/input_conditioner.sv | 127 ++++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// Multi-channel button conditioner: synchronise, debounce, optional invert, press/release/repeat pulses.
// Auto-repeat logic is built only when INPUT_COND_REPEAT_EN is defined; otherwise Repeat is tied low.
module input_conditioner #(
  parameter int                  CHANNELS        = 5,
  parameter int                  SYNC_STAGES     = 2,
  parameter int                  DEBOUNCE_CYCLES = 500000,
  parameter int                  REPEAT_DELAY    = 25000000,
  parameter int                  REPEAT_PERIOD   = 5000000,
  parameter logic [CHANNELS-1:0] INVERT_MASK     = '0
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [CHANNELS-1:0] Raw_In,
  input  logic                Enable,
  output logic [CHANNELS-1:0] Level,
  output logic [CHANNELS-1:0] Press,
  output logic [CHANNELS-1:0] Release,
  output logic [CHANNELS-1:0] Repeat,
  output logic                Any_Press
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync;
  logic [CHANNELS-1:0] accept;
  logic [CHANNELS-1:0] level_nxt;

  // Reset loads logical 0 so an inverted channel idling at its raw inactive level stays released.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= Raw_In ^ INVERT_MASK;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync      = sync_q[SYNC_STAGES-1];
  assign level_nxt = Level ^ accept;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_db
    logic [DW-1:0] db_cnt;

    assign accept[i] = (sync[i] != Level[i]) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)                               db_cnt <= '0;
      else if ((sync[i] == Level[i]) || accept[i]) db_cnt <= '0;
      else                                      db_cnt <= db_cnt + DW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Level     <= '0;
      Press     <= '0;
      Release   <= '0;
      Any_Press <= 1'b0;
    end else begin
      Level     <= level_nxt;
      Press     <= Enable ? (accept & sync)  : '0;
      Release   <= Enable ? (accept & ~sync) : '0;
      Any_Press <= Enable & (|(accept & sync));
    end
  end

`ifdef INPUT_COND_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  typedef enum logic [1:0] {IDLE, DELAY, RPT} rpt_state_t;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_rpt
    rpt_state_t    state;
    logic [RW-1:0] rpt_cnt;

    // DELAY is entered on the press edge itself, so Repeat can never coincide with Press.
    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
        state     <= IDLE;
        rpt_cnt   <= '0;
        Repeat[i] <= 1'b0;
      end else begin
        Repeat[i] <= 1'b0;
        if (!Enable || !level_nxt[i]) begin
          state   <= IDLE;
          rpt_cnt <= '0;
        end else begin
          case (state)
            IDLE: begin
              if (accept[i]) begin
                state   <= DELAY;
                rpt_cnt <= '0;
              end
            end
            DELAY: begin
              if (rpt_cnt == RW'(REPEAT_DELAY - 1)) begin
                Repeat[i] <= 1'b1;
                state     <= RPT;
                rpt_cnt   <= '0;
              end else begin
                rpt_cnt <= rpt_cnt + RW'(1);
              end
            end
            RPT: begin
              if (rpt_cnt == RW'(REPEAT_PERIOD - 1)) begin
                Repeat[i] <= 1'b1;
                rpt_cnt   <= '0;
              end else begin
                rpt_cnt <= rpt_cnt + RW'(1);
              end
            end
            default: begin
              state   <= IDLE;
              rpt_cnt <= '0;
            end
          endcase
        end
      end
    end
  end
`else
  assign Repeat = '0;
`endif

endmodule
